// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with mid-bit sampling.
// A frame is a start bit (0), eight data bits LSB first, and a stop bit (1).
// Each bit lasts OVERSAMPLE clocks. A good frame pulses rx_valid and
// updates rx_data. A bad stop bit pulses rx_frame_err.
// Optional build macro: UART_RX_MAJORITY_EN. When it is defined, every
// sample is the 2-of-3 vote of rx_s over the sample edge and the two
// edges before it.
module uart_receiver #(
  parameter int OVERSAMPLE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  logic          sync1_r;
  logic          rx_s;
  logic          sample_s;

  logic [2:0]    state_r;
  logic [2:0]    state_nx;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx;
  logic [2:0]    idx_r;
  logic [2:0]    idx_nx;
  logic [7:0]    shift_r;
  logic [7:0]    shift_nx;
  logic [7:0]    data_nx;
  logic          valid_nx;
  logic          err_nx;

`ifdef UART_RX_MAJORITY_EN
  // hist_r[0] is the second synchronizer stage. The older bits keep the two
  // previous rx_s values, which the majority vote uses.
  logic [2:0] hist_r;

  function automatic logic maj3(input logic [2:0] v);
    maj3 = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // First sync stage, then a shift through the synchronized history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      hist_r  <= 3'b111;
    end else begin
      sync1_r <= rx;
      hist_r  <= {hist_r[1:0], sync1_r};
    end
  end

  assign rx_s     = hist_r[0];
  assign sample_s = maj3(hist_r);
`else
  logic sync2_r;

  // Two-flop synchronizer for the asynchronous serial line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s     = sync2_r;
  assign sample_s = sync2_r;
`endif

  // Frame-recovery next-state logic and output pulse generation
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    idx_nx   = idx_r;
    shift_nx = shift_r;
    data_nx  = rx_data;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_nx = ST_START;
          cnt_nx   = CNT_ZERO;
        end else begin
          state_nx = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_M1) begin
          if (!sample_s) begin
            state_nx = ST_DATA;
            cnt_nx   = CNT_ZERO;
            idx_nx   = 3'd0;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (cnt_r == FULL_M1) begin
          shift_nx = {sample_s, shift_r[7:1]};
          cnt_nx   = CNT_ZERO;
          idx_nx   = idx_r + 3'd1;
          if (idx_r == 3'd7) begin
            state_nx = ST_STOP;
          end else begin
            state_nx = ST_DATA;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      ST_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nx = CNT_ZERO;
          if (sample_s) begin
            data_nx  = shift_r;
            valid_nx = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            err_nx   = 1'b1;
            state_nx = ST_RECOVER;
          end
        end else begin
          cnt_nx = cnt_r + CNT_ONE;
        end
      end
      ST_RECOVER: begin
        // A held-low line (break) waits here, so it gives only one error
        if (rx_s) begin
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_RECOVER;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      idx_r        <= 3'd0;
      shift_r      <= 8'h00;
      rx_data      <= 8'h00;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_busy      <= 1'b0;
    end else begin
      state_r      <= state_nx;
      cnt_r        <= cnt_nx;
      idx_r        <= idx_nx;
      shift_r      <= shift_nx;
      rx_data      <= data_nx;
      rx_valid     <= valid_nx;
      rx_frame_err <= err_nx;
      rx_busy      <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: per-cycle comparison against a
// frame-level model, plus fixed expectations for each directed scenario.
module tb_uart_receiver;

  localparam int OS   = 8;
  localparam int HALF = OS / 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  uart_receiver #(.OVERSAMPLE(OS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // model state: line delay, frame tracker, expected outputs
  logic       d1 = 1'b1, d2 = 1'b1, h1 = 1'b1, h2 = 1'b1;
  bit         m_idle = 1'b1;
  bit         m_rec  = 1'b0;
  int         e0     = 0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_data = 8'h00;
  logic       exp_valid = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;

  // observation log
  int valid_q[$];
  int err_q[$];
  int busy_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: rx_s is rx two edges late; the frame is decoded by edge offset from E0
  initial begin
    logic cur;
    logic smp;
    int   off;
    int   k;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        d1 = 1'b1; d2 = 1'b1; h1 = 1'b1; h2 = 1'b1;
        m_idle = 1'b1; m_rec = 1'b0; m_data = 8'h00;
        exp_valid = 1'b0; exp_err = 1'b0; exp_busy = 1'b0;
      end else begin
        cur = d2;
`ifdef UART_RX_MAJORITY_EN
        smp = (cur & h1) | (cur & h2) | (h1 & h2);
`else
        smp = cur;
`endif
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (m_idle) begin
          if (cur == 1'b0) begin
            m_idle = 1'b0;
            m_rec  = 1'b0;
            e0     = cyc;
          end
        end else if (m_rec) begin
          if (cur == 1'b1) m_idle = 1'b1;
        end else begin
          off = cyc - e0;
          if (off == HALF) begin
            if (smp) m_idle = 1'b1;
          end else if (off > HALF && ((off - HALF) % OS) == 0) begin
            k = (off - HALF) / OS;
            if (k <= 8) begin
              m_byte[k-1] = smp;
            end else if (smp) begin
              exp_valid = 1'b1;
              m_data    = m_byte;
              m_idle    = 1'b1;
            end else begin
              exp_err = 1'b1;
              m_rec   = 1'b1;
            end
          end
        end
        exp_busy = !m_idle;
        h2 = h1; h1 = cur;
        d2 = d1; d1 = rx;
      end
      #1;
      chk("rx_data",      {24'd0, rx_data},      {24'd0, m_data});
      chk("rx_valid",     {31'd0, rx_valid},     {31'd0, exp_valid});
      chk("rx_frame_err", {31'd0, rx_frame_err}, {31'd0, exp_err});
      chk("rx_busy",      {31'd0, rx_busy},      {31'd0, exp_busy});
      if (rx_valid === 1'b1)     valid_q.push_back(cyc);
      if (rx_frame_err === 1'b1) err_q.push_back(cyc);
      if (rx_busy === 1'b1)      busy_cnt++;
    end
  end

  task automatic clear_log();
    valid_q.delete();
    err_q.delete();
    busy_cnt = 0;
  endtask

  task automatic idle_line(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  // f_edge is the first edge that sees the start bit on rx; E0 = f_edge + 2
  task automatic send_frame(input logic [7:0] b, input logic stop_v,
                            input int glitch_bit, output int f_edge);
    logic [9:0] fr;
    fr = {stop_v, b, 1'b0};
    f_edge = 0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < OS; c++) begin
        @(negedge clk);
        if (i == 0 && c == 0) f_edge = cyc + 1;
        if ((i - 1) == glitch_bit && c == HALF) rx = 1'b0;
        else rx = fr[i];
      end
    end
  endtask

  function automatic int q_at(input int idx, input int which);
    if (which == 0) q_at = (valid_q.size() > idx) ? valid_q[idx] : -1;
    else            q_at = (err_q.size() > idx) ? err_q[idx] : -1;
  endfunction

  initial begin
    int f0, f1, f2;
    logic [9:0] part;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_data",  {24'd0, rx_data}, 32'h0);
    chk("reset_valid", {31'd0, rx_valid}, 32'h0);
    chk("reset_err",   {31'd0, rx_frame_err}, 32'h0);
    chk("reset_busy",  {31'd0, rx_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_line(10);

    // single frame 0xA5
    clear_log();
    send_frame(8'hA5, 1'b1, -1, f0);
    idle_line(20);
    chk("a5_count",   valid_q.size(), 32'd1);
    chk("a5_latency", q_at(0, 0), f0 + 2 + 76);
    chk("a5_data",    {24'd0, rx_data}, 32'h000000A5);
    chk("a5_no_err",  err_q.size(), 32'd0);

    // reset while idle clears the held byte
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("idle_rst_data", {24'd0, rx_data}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle_line(5);

    // reset in the middle of a frame
    part = {1'b1, 8'hC3, 1'b0};
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      rx = part[c / OS];
    end
    @(negedge clk);
    rst_n = 1'b0;
    rx    = 1'b1;
    #1;
    chk("frame_rst_busy", {31'd0, rx_busy}, 32'h0);
    chk("frame_rst_data", {24'd0, rx_data}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_log();
    idle_line(100);
    chk("post_rst_valid", valid_q.size(), 32'd0);
    chk("post_rst_err",   err_q.size(), 32'd0);
    chk("post_rst_busy",  busy_cnt, 32'd0);

    // back-to-back frames, no idle gap
    clear_log();
    send_frame(8'h00, 1'b1, -1, f0);
    send_frame(8'hFF, 1'b1, -1, f1);
    send_frame(8'h3C, 1'b1, -1, f2);
    idle_line(20);
    chk("b2b_count",  valid_q.size(), 32'd3);
    chk("b2b_first",  q_at(0, 0), f0 + 78);
    chk("b2b_gap1",   q_at(1, 0) - q_at(0, 0), 32'd80);
    chk("b2b_gap2",   q_at(2, 0) - q_at(1, 0), 32'd80);
    chk("b2b_data",   {24'd0, rx_data}, 32'h0000003C);

    // false start: two low cycles
    clear_log();
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b0;
    idle_line(20);
    chk("fs_busy_cycles", busy_cnt, 32'd4);
    chk("fs_valid",       valid_q.size(), 32'd0);
    chk("fs_err",         err_q.size(), 32'd0);

    // framing error: stop bit 0, then line low for 30 more cycles
    clear_log();
    send_frame(8'h5A, 1'b0, -1, f0);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      rx = 1'b0;
    end
    idle_line(20);
    chk("fe_count",       err_q.size(), 32'd1);
    chk("fe_when",        q_at(0, 1), f0 + 78);
    chk("fe_no_valid",    valid_q.size(), 32'd0);
    chk("fe_data_kept",   {24'd0, rx_data}, 32'h0000003C);
    chk("fe_busy_cycles", busy_cnt, 32'd110);

    // one-cycle low glitch at the sample point of data bit 3
    clear_log();
    send_frame(8'hFF, 1'b1, 3, f0);
    idle_line(20);
    chk("gl_count", valid_q.size(), 32'd1);
`ifdef UART_RX_MAJORITY_EN
    chk("gl_data", {24'd0, rx_data}, 32'h000000FF);
`else
    chk("gl_data", {24'd0, rx_data}, 32'h000000F7);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
